game_flow_ctrl: RTL

Parametrised top-level game flow controller for the jetpack runner. It replaces the fixed three-state start/playing/game-over machine with a five-state sequencer that adds a respawn countdown, pause/resume, a lives counter and a game-over input lockout. It sits between the debounced button inputs, the collision detector and the frame-tick generator, and drives the state code consumed by the renderer and scorer.

---
 rtl/game_flow_ctrl.sv | 137 +++++++++++++
 1 files changed

// File: rtl/game_flow_ctrl.sv
// ============================================================================
// game_flow_ctrl : five-state jetpack-runner flow sequencer (start, countdown,
//                  playing, paused, game-over) with lives and input lockout.
// Revision 1.0
// ============================================================================
`default_nettype none

module game_flow_ctrl #(
  parameter int LIVES           = 3,
  parameter int COUNTDOWN_TICKS = 3,
  parameter int HOLD_TICKS      = 2,
  parameter int LW              = $clog2(LIVES + 1),
  parameter int CW              = $clog2(((COUNTDOWN_TICKS > HOLD_TICKS) ?
                                          COUNTDOWN_TICKS : HOLD_TICKS) + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic          pause,
  input  logic          hit,
  input  logic          tick,
  output logic [2:0]    game_state,
  output logic [LW-1:0] lives,
  output logic [CW-1:0] countdown,
  output logic          playing,
  output logic          round_start
);

  typedef enum logic [2:0] {
    ST_START     = 3'b000,
    ST_PLAYING   = 3'b001,
    ST_GAME_OVER = 3'b010,
    ST_COUNTDOWN = 3'b011,
    ST_PAUSED    = 3'b100
  } state_t;

  state_t          state_q, state_d;
  logic [LW-1:0]   lives_q, lives_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            round_start_q, round_start_d;
  logic            playing_q;
  logic            start_q, pause_q;
  logic            start_p, pause_p;

  // Edge registers come out of reset high so a held button must be re-pressed.
  assign start_p = start & ~start_q;
  assign pause_p = pause & ~pause_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= ST_START;
      lives_q       <= '0;
      cnt_q         <= '0;
      round_start_q <= 1'b0;
      playing_q     <= 1'b0;
      start_q       <= 1'b1;
      pause_q       <= 1'b1;
    end else begin
      state_q       <= state_d;
      lives_q       <= lives_d;
      cnt_q         <= cnt_d;
      round_start_q <= round_start_d;
      playing_q     <= (state_d == ST_PLAYING);
      start_q       <= start;
      pause_q       <= pause;
    end
  end

  always_comb begin
    state_d       = state_q;
    lives_d       = lives_q;
    cnt_d         = cnt_q;
    round_start_d = 1'b0;
    unique case (state_q)
      ST_START: begin
        if (start_p) begin
          state_d = ST_COUNTDOWN;
          lives_d = LW'(LIVES);
          cnt_d   = CW'(COUNTDOWN_TICKS);
        end
      end
      ST_COUNTDOWN: begin
        if (tick) begin
          if (cnt_q <= CW'(1)) begin
            state_d       = ST_PLAYING;
            cnt_d         = '0;
            round_start_d = 1'b1;
          end else begin
            cnt_d = cnt_q - CW'(1);
          end
        end
      end
      ST_PLAYING: begin
        if (hit) begin
          if (lives_q <= LW'(1)) begin
            state_d = ST_GAME_OVER;
            lives_d = '0;
            cnt_d   = CW'(HOLD_TICKS);
          end else begin
            state_d = ST_COUNTDOWN;
            lives_d = lives_q - LW'(1);
            cnt_d   = CW'(COUNTDOWN_TICKS);
          end
        end else if (pause_p) begin
          state_d = ST_PAUSED;
        end
      end
      ST_PAUSED: begin
        if (pause_p || start_p) begin
          state_d = ST_PLAYING;
        end
      end
      ST_GAME_OVER: begin
        // A tick that drains the lockout swallows a coincident start press.
        if (tick && (cnt_q != '0)) begin
          cnt_d = cnt_q - CW'(1);
        end else if (start_p && (cnt_q == '0)) begin
          state_d = ST_START;
        end
      end
      default: begin
        state_d = ST_START;
        lives_d = '0;
        cnt_d   = '0;
      end
    endcase
  end

  assign game_state  = state_q;
  assign lives       = lives_q;
  assign countdown   = cnt_q;
  assign playing     = playing_q;
  assign round_start = round_start_q;

endmodule

`default_nettype wire
